// File: rtl/wb_mem_stage_reg_pkg.sv
// Shared types and constants for the MEM->WB segment register and its cache controller.
package wb_mem_stage_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MISS = 2'd1,
        ST_DONE = 2'd2
    } wb_state_e;

    // RegWrite / load-type codes shared with the WB data extender
    localparam logic [2:0] RW_NONE  = 3'b000;
    localparam logic [2:0] RW_WORD  = 3'b001;
    localparam logic [2:0] RW_HALF  = 3'b010;
    localparam logic [2:0] RW_HALFU = 3'b011;
    localparam logic [2:0] RW_BYTE  = 3'b100;
    localparam logic [2:0] RW_BYTEU = 3'b101;

endpackage

// File: rtl/wb_mem_stage_reg_perf_counter.sv
// Saturating event counter; built only when WB_PERF_CNT_EN is defined.
`ifdef WB_PERF_CNT_EN
module wb_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Stick at all-ones instead of wrapping
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`endif

// File: rtl/wb_mem_stage_reg.sv
// MEM->WB segment register with data-cache access controller, RD stall hold and
// optional hit/miss performance counters (macro WB_PERF_CNT_EN).
module wb_mem_stage_reg
    import wb_mem_stage_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5,
    parameter int RW_W   = 3,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clear,
    input  logic [ADDR_W-1:0]   A,
    input  logic [DATA_W-1:0]   WD,
    input  logic [DATA_W/8-1:0] WE,
    input  logic                MemToRegM,
    input  logic [DATA_W-1:0]   ResultM,
    input  logic [REG_AW-1:0]   RdM,
    input  logic [RW_W-1:0]     RegWriteM,
    output logic [ADDR_W-1:0]   c_addr,
    output logic [DATA_W-1:0]   c_wr_data,
    output logic [DATA_W/8-1:0] c_be,
    output logic                c_rd_req,
    output logic                c_wr_req,
    input  logic                c_miss,
    input  logic [DATA_W-1:0]   c_rd_data,
    output logic                stall_req,
    output logic [DATA_W-1:0]   RD,
    output logic [1:0]          LoadedBytesSelect,
    output logic [DATA_W-1:0]   ResultW,
    output logic [REG_AW-1:0]   RdW,
    output logic [RW_W-1:0]     RegWriteW,
    output logic                MemToRegW,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt,
    output logic [CNT_W-1:0]    miss_cyc_cnt
);

    wb_state_e         state_q;
    wb_state_e         state_d;
    logic              access;

    logic [1:0]        lbs_q;
    logic [DATA_W-1:0] result_q;
    logic [REG_AW-1:0] rd_q;
    logic [RW_W-1:0]   regwrite_q;
    logic              memtoreg_q;

    logic [DATA_W-1:0] hold_data_q;
    logic              hold_flag_q;

    assign c_addr    = A;
    assign c_wr_data = WD;
    assign c_be      = WE;
    assign c_rd_req  = MemToRegM;
    assign c_wr_req  = |WE;

    assign access    = c_rd_req | c_wr_req;
    assign stall_req = access & c_miss;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DONE parks the finished access until the pipeline advances, so a
    // re-presented access during a stall is not treated as a new one
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (access && c_miss) begin
                    state_d = ST_MISS;
                end else if (access) begin
                    state_d = ST_DONE;
                end
            end
            ST_MISS: begin
                if (!c_miss) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (en) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // clear only kills the write-back side effects; result/rd still follow en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lbs_q      <= '0;
            result_q   <= '0;
            rd_q       <= '0;
            regwrite_q <= '0;
            memtoreg_q <= 1'b0;
        end else begin
            if (en) begin
                lbs_q      <= A[1:0];
                result_q   <= ResultM;
                rd_q       <= RdM;
                regwrite_q <= RegWriteM;
                memtoreg_q <= MemToRegM;
            end
            if (clear) begin
                regwrite_q <= RW_W'(RW_NONE);
                memtoreg_q <= 1'b0;
            end
        end
    end

    assign LoadedBytesSelect = lbs_q;
    assign ResultW           = result_q;
    assign RdW               = rd_q;
    assign RegWriteW         = regwrite_q;
    assign MemToRegW         = memtoreg_q;

    // Capturing RD (not c_rd_data) freezes the first stalled value for the whole stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data_q <= '0;
            hold_flag_q <= 1'b0;
        end else if (!en) begin
            hold_data_q <= RD;
            hold_flag_q <= 1'b1;
        end else begin
            hold_flag_q <= 1'b0;
        end
    end

    assign RD = hold_flag_q ? hold_data_q : c_rd_data;

`ifdef WB_PERF_CNT_EN
    logic hit_inc;
    logic miss_inc;
    logic miss_cyc_inc;

    assign hit_inc      = (state_q == ST_IDLE) & access & ~c_miss;
    assign miss_inc     = (state_q == ST_IDLE) & access & c_miss;
    assign miss_cyc_inc = (state_q == ST_MISS);

    wb_perf_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (hit_inc),
        .count_o (hit_cnt)
    );

    wb_perf_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (miss_inc),
        .count_o (miss_cnt)
    );

    wb_perf_counter #(.CNT_W(CNT_W)) u_miss_cyc_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (miss_cyc_inc),
        .count_o (miss_cyc_cnt)
    );
`else
    assign hit_cnt      = '0;
    assign miss_cnt     = '0;
    assign miss_cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_mem_stage_reg.sv
// Scoreboard bench for wb_mem_stage_reg: stimulus pushes expected values, a
// negedge monitor pops and compares them.
module tb_wb_mem_stage_reg;

    import wb_mem_stage_reg_pkg::*;

`ifdef WB_PERF_CNT_EN
    localparam logic PERF = 1'b1;
`else
    localparam logic PERF = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic        clear;
    logic [31:0] A;
    logic [31:0] WD;
    logic [3:0]  WE;
    logic        MemToRegM;
    logic [31:0] ResultM;
    logic [4:0]  RdM;
    logic [2:0]  RegWriteM;
    logic [31:0] c_addr;
    logic [31:0] c_wr_data;
    logic [3:0]  c_be;
    logic        c_rd_req;
    logic        c_wr_req;
    logic        c_miss;
    logic [31:0] c_rd_data;
    logic        stall_req;
    logic [31:0] RD;
    logic [1:0]  LoadedBytesSelect;
    logic [31:0] ResultW;
    logic [4:0]  RdW;
    logic [2:0]  RegWriteW;
    logic        MemToRegW;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    logic [31:0] miss_cyc_cnt;

    typedef enum {
        K_STALL, K_RD, K_LBS, K_RESW, K_RDW, K_RWW, K_M2RW,
        K_HIT, K_MISS, K_MCYC, K_CADDR, K_CRD, K_CWR, K_CWD, K_CBE
    } kind_e;

    typedef struct {
        int          cyc;
        kind_e       kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sbQ[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    wb_mem_stage_reg dut (
        .clk               (clk),
        .rst               (rst),
        .en                (en),
        .clear             (clear),
        .A                 (A),
        .WD                (WD),
        .WE                (WE),
        .MemToRegM         (MemToRegM),
        .ResultM           (ResultM),
        .RdM               (RdM),
        .RegWriteM         (RegWriteM),
        .c_addr            (c_addr),
        .c_wr_data         (c_wr_data),
        .c_be              (c_be),
        .c_rd_req          (c_rd_req),
        .c_wr_req          (c_wr_req),
        .c_miss            (c_miss),
        .c_rd_data         (c_rd_data),
        .stall_req         (stall_req),
        .RD                (RD),
        .LoadedBytesSelect (LoadedBytesSelect),
        .ResultW           (ResultW),
        .RdW               (RdW),
        .RegWriteW         (RegWriteW),
        .MemToRegW         (MemToRegW),
        .hit_cnt           (hit_cnt),
        .miss_cnt          (miss_cnt),
        .miss_cyc_cnt      (miss_cyc_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Counters read as zero when the perf feature is compiled out
    function automatic logic [31:0] cnt(input int v);
        return PERF ? 32'(v) : 32'd0;
    endfunction

    task automatic pushExp(input kind_e k, input logic [31:0] v);
        exp_t e;
        e.cyc  = cyc;
        e.kind = k;
        e.exp  = v;
        sbQ.push_back(e);
    endtask

    task automatic applyStimulus(
        input logic        rst_v,
        input logic        en_v,
        input logic        clr_v,
        input logic [31:0] a_v,
        input logic [31:0] wd_v,
        input logic [3:0]  we_v,
        input logic        m2r_v,
        input logic [31:0] res_v,
        input logic [4:0]  rd_v,
        input logic [2:0]  rw_v,
        input logic        miss_v,
        input logic [31:0] rdata_v
    );
        @(posedge clk);
        #1;
        rst       = rst_v;
        en        = en_v;
        clear     = clr_v;
        A         = a_v;
        WD        = wd_v;
        WE        = we_v;
        MemToRegM = m2r_v;
        ResultM   = res_v;
        RdM       = rd_v;
        RegWriteM = rw_v;
        c_miss    = miss_v;
        c_rd_data = rdata_v;
    endtask

    task automatic bubble(input logic [31:0] rdata_v);
        applyStimulus(0, 1, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 5'd0, 3'd0, 0, rdata_v);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [31:0] act;
        act = 32'h0;
        case (e.kind)
            K_STALL: act = {31'b0, stall_req};
            K_RD:    act = RD;
            K_LBS:   act = {30'b0, LoadedBytesSelect};
            K_RESW:  act = ResultW;
            K_RDW:   act = {27'b0, RdW};
            K_RWW:   act = {29'b0, RegWriteW};
            K_M2RW:  act = {31'b0, MemToRegW};
            K_HIT:   act = hit_cnt;
            K_MISS:  act = miss_cnt;
            K_MCYC:  act = miss_cyc_cnt;
            K_CADDR: act = c_addr;
            K_CRD:   act = {31'b0, c_rd_req};
            K_CWR:   act = {31'b0, c_wr_req};
            K_CWD:   act = c_wr_data;
            K_CBE:   act = {28'b0, c_be};
            default: act = 32'hxxxx_xxxx;
        endcase
        compared++;
        if (act !== e.exp) begin
            mismatched++;
            $display("[TB] FAIL %s cyc=%0d actual=0x%08h expected=0x%08h",
                     e.kind.name(), e.cyc, act, e.exp);
        end
    endtask

    // Monitor: everything queued for this cycle is compared mid-cycle
    always @(negedge clk) begin
        while (sbQ.size() > 0 && sbQ[0].cyc <= cyc) begin
            if (sbQ[0].cyc < cyc) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL %s stale cyc=%0d now=%0d", sbQ[0].kind.name(), sbQ[0].cyc, cyc);
                void'(sbQ.pop_front());
            end else begin
                checkOutput(sbQ.pop_front());
            end
        end
    end

    initial begin
        #100000;
        mismatched++;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        rst = 1'b1; en = 1'b1; clear = 1'b0; A = '0; WD = '0; WE = '0;
        MemToRegM = 1'b0; ResultM = '0; RdM = '0; RegWriteM = '0;
        c_miss = 1'b0; c_rd_data = '0;

        // Reset state, with non-zero inputs that must not be latched
        applyStimulus(1, 1, 0, 32'h0, 32'h0, 4'h0, 0, 32'hFFFF, 5'd3, 3'd1, 0, 32'h1234);
        pushExp(K_RESW, 32'h0); pushExp(K_RDW, 32'h0); pushExp(K_RWW, 32'h0);
        pushExp(K_M2RW, 32'h0); pushExp(K_LBS, 32'h0); pushExp(K_HIT, 32'h0);
        pushExp(K_MISS, 32'h0); pushExp(K_MCYC, 32'h0); pushExp(K_STALL, 32'h0);
        pushExp(K_RD, 32'h1234);

        // Load hit
        applyStimulus(0, 1, 0, 32'h106, 32'h0, 4'h0, 1, 32'h106, 5'd5, 3'd1, 0, 32'hCAFEBABE);
        pushExp(K_STALL, 32'h0); pushExp(K_CRD, 32'h1); pushExp(K_CWR, 32'h0);
        pushExp(K_CADDR, 32'h106); pushExp(K_HIT, cnt(0));
        bubble(32'hCAFEBABE);
        pushExp(K_RD, 32'hCAFEBABE); pushExp(K_HIT, cnt(1)); pushExp(K_LBS, 32'h2);
        pushExp(K_RESW, 32'h106); pushExp(K_RDW, 32'd5); pushExp(K_RWW, 32'd1);
        pushExp(K_M2RW, 32'h1);

        // Two loads to 0x100, each followed by the bubble that DONE consumes
        applyStimulus(0, 1, 0, 32'h100, 32'h0, 4'h0, 1, 32'h100, 5'd6, 3'd1, 0, 32'h0);
        bubble(32'h0);
        pushExp(K_HIT, cnt(2)); pushExp(K_RDW, 32'd6);
        applyStimulus(0, 1, 0, 32'h100, 32'h0, 4'h0, 1, 32'h100, 5'd7, 3'd1, 0, 32'h0);
        bubble(32'h0);
        pushExp(K_HIT, cnt(3)); pushExp(K_RDW, 32'd7); pushExp(K_LBS, 32'h0);

        // Store hit
        applyStimulus(0, 1, 0, 32'h400, 32'h12345678, 4'b0011, 0, 32'h400, 5'd0, 3'd0, 0, 32'h0);
        pushExp(K_CWR, 32'h1); pushExp(K_CRD, 32'h0); pushExp(K_CWD, 32'h12345678);
        pushExp(K_CBE, 32'h3);
        bubble(32'h0);
        pushExp(K_HIT, cnt(4)); pushExp(K_M2RW, 32'h0);

        // Load miss, c_miss high for 4 cycles, en low while stalled
        applyStimulus(0, 0, 0, 32'h203, 32'h0, 4'h0, 1, 32'h203, 5'd8, 3'd1, 1, 32'h11111111);
        pushExp(K_STALL, 32'h1); pushExp(K_MISS, cnt(0));
        applyStimulus(0, 0, 0, 32'h203, 32'h0, 4'h0, 1, 32'h203, 5'd8, 3'd1, 1, 32'h11111111);
        pushExp(K_STALL, 32'h1); pushExp(K_MISS, cnt(1)); pushExp(K_MCYC, cnt(0));
        applyStimulus(0, 0, 0, 32'h203, 32'h0, 4'h0, 1, 32'h203, 5'd8, 3'd1, 1, 32'h22222222);
        pushExp(K_STALL, 32'h1); pushExp(K_MCYC, cnt(1)); pushExp(K_RD, 32'h11111111);
        applyStimulus(0, 0, 0, 32'h203, 32'h0, 4'h0, 1, 32'h203, 5'd8, 3'd1, 1, 32'h22222222);
        pushExp(K_STALL, 32'h1); pushExp(K_MCYC, cnt(2)); pushExp(K_RDW, 32'd0);
        applyStimulus(0, 1, 0, 32'h203, 32'h0, 4'h0, 1, 32'h203, 5'd8, 3'd1, 0, 32'hDEADBEEF);
        pushExp(K_STALL, 32'h0); pushExp(K_MCYC, cnt(3));
        bubble(32'h0);
        pushExp(K_MCYC, cnt(4)); pushExp(K_MISS, cnt(1)); pushExp(K_HIT, cnt(4));
        pushExp(K_RDW, 32'd8); pushExp(K_LBS, 32'h3); pushExp(K_M2RW, 32'h1);

        // Stall hold: load hit, then en low for 3 cycles with c_rd_data moving
        applyStimulus(0, 1, 0, 32'h301, 32'h0, 4'h0, 1, 32'h301, 5'd9, 3'd2, 0, 32'hA5A5A5A5);
        pushExp(K_STALL, 32'h0);
        applyStimulus(0, 0, 0, 32'h301, 32'h0, 4'h0, 1, 32'h999, 5'd12, 3'd2, 0, 32'hA5A5A5A5);
        pushExp(K_RD, 32'hA5A5A5A5); pushExp(K_HIT, cnt(5)); pushExp(K_RDW, 32'd9);
        pushExp(K_RESW, 32'h301); pushExp(K_LBS, 32'h1);
        applyStimulus(0, 0, 0, 32'h301, 32'h0, 4'h0, 1, 32'h999, 5'd12, 3'd2, 0, 32'h5A5A5A5A);
        pushExp(K_RD, 32'hA5A5A5A5); pushExp(K_RDW, 32'd9);
        applyStimulus(0, 0, 0, 32'h301, 32'h0, 4'h0, 1, 32'h999, 5'd12, 3'd2, 0, 32'h0F0F0F0F);
        pushExp(K_RD, 32'hA5A5A5A5); pushExp(K_RESW, 32'h301); pushExp(K_HIT, cnt(5));
        pushExp(K_RWW, 32'd2);
        bubble(32'h0);
        pushExp(K_HIT, cnt(5)); pushExp(K_RD, 32'hA5A5A5A5);

        // clear with en high, then clear with en low
        applyStimulus(0, 1, 1, 32'h3, 32'h0, 4'h0, 0, 32'h55, 5'd17, 3'b010, 0, 32'h0);
        applyStimulus(0, 1, 0, 32'h2, 32'h0, 4'h0, 0, 32'h77, 5'd18, 3'd3, 0, 32'h0);
        pushExp(K_RWW, 32'h0); pushExp(K_M2RW, 32'h0); pushExp(K_RESW, 32'h55);
        pushExp(K_RDW, 32'd17); pushExp(K_LBS, 32'h3); pushExp(K_HIT, cnt(5));
        applyStimulus(0, 0, 1, 32'h0, 32'h0, 4'h0, 0, 32'h88, 5'd19, 3'd4, 0, 32'h0);
        pushExp(K_RWW, 32'd3); pushExp(K_RESW, 32'h77); pushExp(K_RDW, 32'd18);
        bubble(32'h0);
        pushExp(K_RWW, 32'h0); pushExp(K_RESW, 32'h77); pushExp(K_RDW, 32'd18);
        pushExp(K_LBS, 32'h2);

        // Reset while in MISS, then a re-issued miss counted once
        applyStimulus(0, 0, 0, 32'h500, 32'h0, 4'h0, 1, 32'h500, 5'd21, 3'd1, 1, 32'h0);
        pushExp(K_STALL, 32'h1); pushExp(K_MISS, cnt(1));
        applyStimulus(0, 0, 0, 32'h500, 32'h0, 4'h0, 1, 32'h500, 5'd21, 3'd1, 1, 32'h0);
        pushExp(K_MISS, cnt(2)); pushExp(K_MCYC, cnt(4));
        applyStimulus(1, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 5'd0, 3'd0, 0, 32'h77);
        pushExp(K_HIT, 32'h0); pushExp(K_MISS, 32'h0); pushExp(K_MCYC, 32'h0);
        pushExp(K_RESW, 32'h0); pushExp(K_RDW, 32'h0); pushExp(K_RWW, 32'h0);
        pushExp(K_M2RW, 32'h0); pushExp(K_LBS, 32'h0); pushExp(K_STALL, 32'h0);
        pushExp(K_RD, 32'h77);
        bubble(32'h0);
        applyStimulus(0, 0, 0, 32'h504, 32'h0, 4'h0, 1, 32'h504, 5'd22, 3'd1, 1, 32'h0);
        pushExp(K_STALL, 32'h1); pushExp(K_MISS, cnt(0));
        applyStimulus(0, 1, 0, 32'h504, 32'h0, 4'h0, 1, 32'h504, 5'd22, 3'd1, 0, 32'hBEEF);
        pushExp(K_STALL, 32'h0); pushExp(K_MISS, cnt(1)); pushExp(K_MCYC, cnt(0));
        bubble(32'h0);
        pushExp(K_MISS, cnt(1)); pushExp(K_MCYC, cnt(1)); pushExp(K_HIT, cnt(0));
        pushExp(K_RDW, 32'd22);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        while (sbQ.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s never checked cyc=%0d", sbQ[0].kind.name(), sbQ[0].cyc);
            void'(sbQ.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
